// File: rtl/clk_div_n.sv
// Programmable 50%-duty integer clock divider (N = 2..2^W-1, odd or even).
// Define CLK_DIV_N_ERR_EN to add the div_err flag for rejected divisor loads.
module clk_div_n #(
  parameter int W         = 8,
  parameter int DIV_RESET = 5
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         clk_out,
  output logic [W-1:0] div_act,
  output logic         div_pend,
`ifdef CLK_DIV_N_ERR_EN
  output logic         div_err,
`endif
  output logic         period_tick
);

  localparam logic [W-1:0] DIV_RST = W'(DIV_RESET);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_pend_val;
  logic         r_hi;
  logic         r_nf;

  logic [W-1:0] w_last;
  logic [W-1:0] w_mid;
  logic         w_load_ok;
  logic         w_bnd;
  logic         w_halt;
  logic         w_apply;

  // w_mid is the last count of the high phase: N/2 for even N, (N+1)/2 for odd N.
  assign w_last    = div_act - W'(1);
  assign w_mid     = (div_act >> 1) + W'(div_act[0]);
  assign w_load_ok = div_load && (div_in > W'(1));
  assign w_bnd     = (r_cnt == w_last);
  assign w_halt    = (r_cnt == '0) && !en;
  assign w_apply   = w_bnd || w_halt;

  assign period_tick = !rst_in && en && (r_cnt == '0);

  // The negedge flag only masks the final half cycle of an odd high phase, so
  // every transition of clk_out comes from exactly one flop changing.
  assign clk_out = r_hi & ~r_nf;

  // Rising-edge stage: counter, high-phase level, divisor bookkeeping
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt    <= '0;
      r_hi     <= 1'b0;
      div_act  <= DIV_RST;
      div_pend <= 1'b0;
    end else begin
      if (r_cnt == '0)
        r_cnt <= en ? W'(1) : '0;
      else if (w_bnd)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + W'(1);

      if (r_cnt == '0)
        r_hi <= en;
      else if (r_cnt == w_mid)
        r_hi <= 1'b0;

      if (w_apply) begin
        if (w_load_ok)
          div_act <= div_in;
        else if (div_pend)
          div_act <= r_pend_val;
        div_pend <= 1'b0;
      end else if (w_load_ok) begin
        div_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_load_ok)
      r_pend_val <= div_in;
  end

  // Falling-edge stage: half-cycle fall for odd divisors
  always_ff @(negedge clk_in) begin
    if (rst_in)
      r_nf <= 1'b0;
    else
      r_nf <= div_act[0] && (r_cnt == w_mid);
  end

`ifdef CLK_DIV_N_ERR_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)
      div_err <= 1'b0;
    else if (div_load)
      div_err <= !w_load_ok;
  end
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// Directed bench for clk_div_n: half-cycle waveform model plus literal duty/latency checks.
`timescale 1ns/1ps
module tb_clk_div_n;
  localparam int W         = 8;
  localparam int DIV_RESET = 5;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         clk_out;
  logic [W-1:0] div_act;
  logic         div_pend;
  logic         period_tick;
`ifdef CLK_DIV_N_ERR_EN
  logic         div_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  clk_div_n #(.W(W), .DIV_RESET(DIV_RESET)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .div_act    (div_act),
    .div_pend   (div_pend),
`ifdef CLK_DIV_N_ERR_EN
    .div_err    (div_err),
`endif
    .period_tick(period_tick)
  );

  // Model: m_ph = whole cycles elapsed since the current period's rise (0 = rise pending/idle).
  // clk_out is high for the first m_n half cycles after the rise.
  int m_ph    = 0;
  int m_n     = DIV_RESET;
  int m_pval  = 0;
  bit m_pend  = 1'b0;
  bit m_err   = 1'b0;
  bit chk_en  = 1'b0;
  int hi_halves = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit l, input int d);
    bit ok;
    bit bnd;
    bit halt;
    int nph;
    if (r) begin
      m_ph = 0; m_n = DIV_RESET; m_pend = 1'b0; m_err = 1'b0;
    end else begin
      ok   = l && (d >= 2);
      if (l) m_err = !ok;
      bnd  = (m_ph != 0) && (m_ph == m_n - 1);
      halt = (m_ph == 0) && !e;
      nph  = (m_ph == 0) ? (e ? 1 : 0) : (bnd ? 0 : m_ph + 1);
      if (bnd || halt) begin
        if (ok) m_n = d;
        else if (m_pend) m_n = m_pval;
        m_pend = 1'b0;
      end else if (ok) begin
        m_pend = 1'b1;
        m_pval = d;
      end
      m_ph = nph;
    end
  endtask

  initial begin
    bit r_s;
    bit e_s;
    bit exp_first;
    bit exp_second;
    forever begin
      @(posedge clk_in);
      model_step(rst_in, en, div_load, int'(div_in));
      #1;
      exp_first = (m_ph >= 1) && (2 * (m_ph - 1) < m_n);
      if (chk_en) begin
        chk("clk_out_first_half", int'(clk_out), int'(exp_first));
        if (clk_out) hi_halves++;
      end
      @(negedge clk_in);
      r_s = rst_in;
      e_s = en;
      #1;
      exp_second = r_s ? exp_first : ((m_ph >= 1) && (2 * (m_ph - 1) + 1 < m_n));
      if (chk_en) begin
        chk("clk_out_second_half", int'(clk_out), int'(exp_second));
        if (clk_out) hi_halves++;
        chk("div_act", int'(div_act), m_n);
        chk("div_pend", int'(div_pend), int'(m_pend));
        chk("period_tick", int'(period_tick), int'(!r_s && e_s && (m_ph == 0)));
`ifdef CLK_DIV_N_ERR_EN
        chk("div_err", int'(div_err), int'(m_err));
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic wait_ph(input int p);
    int k;
    k = 0;
    while (m_ph != p && k < 1000) begin
      tick(1);
      k++;
    end
    chk("wait_phase_reached", m_ph, p);
  endtask

  task automatic wait_n(input int n);
    int k;
    k = 0;
    while (m_n != n && k < 1000) begin
      tick(1);
      k++;
    end
    chk("wait_divisor_applied", m_n, n);
  endtask

  task automatic load(input int v);
    div_in   = W'(v);
    div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
  endtask

  int h0;
  int sweep [5] = '{2, 3, 7, 8, 255};

  initial begin
    rst_in = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
    tick(2);
    chk_en = 1'b1;
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_div_act", int'(div_act), 5);
    chk("reset_div_pend", int'(div_pend), 0);
    chk("reset_period_tick", int'(period_tick), 0);

    // Default N=5: first rise one edge after release, 2.5 cycles high per 5
    rst_in = 1'b0; en = 1'b1;
    #1;
    chk("startup_tick", int'(period_tick), 1);
    tick(1);
    chk("first_rise", int'(clk_out), 1);
    h0 = hi_halves;
    tick(100);
    chk("n5_high_halves_20_periods", hi_halves - h0, 100);

    // Mid-period load of 4 waits for the boundary
    wait_ph(2);
    load(4);
    chk("load4_pending", int'(div_pend), 1);
    chk("load4_act_still_5", int'(div_act), 5);
    wait_ph(0);
    chk("load4_applied", int'(div_act), 4);
    chk("load4_pend_cleared", int'(div_pend), 0);
    h0 = hi_halves;
    tick(40);
    chk("n4_high_halves_10_periods", hi_halves - h0, 40);

    // Loads in the last cycle of a period apply at that same boundary
    foreach (sweep[i]) begin
      wait_ph(m_n - 1);
      load(sweep[i]);
      chk("sweep_act", int'(div_act), sweep[i]);
      chk("sweep_pend", int'(div_pend), 0);
      h0 = hi_halves;
      tick(2 * sweep[i]);
      chk("sweep_high_halves_2_periods", hi_halves - h0, 2 * sweep[i]);
    end

    // Enable drop at cnt==2 under N=6
    wait_ph(m_n - 1);
    load(6);
    chk("n6_applied", int'(div_act), 6);
    wait_ph(2);
    en = 1'b0;
    h0 = hi_halves;
    tick(10);
    chk("en_drop_remaining_high_halves", hi_halves - h0, 3);
    chk("parked_clk_out", int'(clk_out), 0);
    chk("parked_tick", int'(period_tick), 0);
    en = 1'b1;
    #1;
    chk("reenable_tick", int'(period_tick), 1);
    tick(1);
    chk("reenable_rise", int'(clk_out), 1);

    // Invalid loads are ignored
    load(1);
    chk("load1_act", int'(div_act), 6);
    chk("load1_pend", int'(div_pend), 0);
`ifdef CLK_DIV_N_ERR_EN
    chk("load1_err", int'(div_err), 1);
`endif
    load(0);
    chk("load0_act", int'(div_act), 6);
    chk("load0_pend", int'(div_pend), 0);
`ifdef CLK_DIV_N_ERR_EN
    chk("load0_err", int'(div_err), 1);
`endif
    load(9);
`ifdef CLK_DIV_N_ERR_EN
    chk("load9_err_cleared", int'(div_err), 0);
`endif
    wait_n(9);
    tick(20);

    // Reset in the high phase with a load pending
    wait_ph(1);
    load(7);
    chk("pre_reset_pend", int'(div_pend), 1);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    chk("mid_reset_clk_out", int'(clk_out), 0);
    chk("mid_reset_div_act", int'(div_act), 5);
    chk("mid_reset_div_pend", int'(div_pend), 0);
    tick(1);
    chk("restart_rise", int'(clk_out), 1);
    tick(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
